// File: rtl/pc_gen_ras_pkg.sv
// Shared constants and next-PC source encoding for the fetch PC generator.
package pc_gen_ras_pkg;

  localparam int          PC_WIDTH_DEF = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;

  typedef enum logic [2:0] {
    SRC_REDIRECT,
    SRC_RAS,
    SRC_BRANCH,
    SRC_JAL,
    SRC_SEQ
  } npc_src_e;

endpackage

// File: rtl/pc_gen_ras_if.sv
// Fetch mini-decoder <-> next-PC generator bundle; slave is the PC generator.
interface pc_gen_ras_if #(
  parameter int PC_WIDTH = pc_gen_ras_pkg::PC_WIDTH_DEF
);
  logic                stall_i;
  logic                ex_redirect_i;
  logic [PC_WIDTH-1:0] ex_redirect_pc_i;
  logic                mini_op_branch_i;
  logic                F_train_predict_i;
  logic [PC_WIDTH-1:0] mini_branch_jmp_i;
  logic                mini_op_jal_i;
  logic [PC_WIDTH-1:0] mini_jal_jmp_i;
  logic                mini_op_call_i;
  logic                mini_op_ret_i;
  logic [PC_WIDTH-1:0] F_PC_o;
  logic [PC_WIDTH-1:0] nPC_o;
  logic                ras_empty_o;
  logic                ras_full_o;

  modport master (
    output stall_i, ex_redirect_i, ex_redirect_pc_i, mini_op_branch_i,
           F_train_predict_i, mini_branch_jmp_i, mini_op_jal_i, mini_jal_jmp_i,
           mini_op_call_i, mini_op_ret_i,
    input  F_PC_o, nPC_o, ras_empty_o, ras_full_o
  );

  modport slave (
    input  stall_i, ex_redirect_i, ex_redirect_pc_i, mini_op_branch_i,
           F_train_predict_i, mini_branch_jmp_i, mini_op_jal_i, mini_jal_jmp_i,
           mini_op_call_i, mini_op_ret_i,
    output F_PC_o, nPC_o, ras_empty_o, ras_full_o
  );
endinterface

// File: rtl/pc_gen_ras_ras_stack.sv
// Circular return address stack: top at ptr, push writes ptr+1, overflow drops oldest.
module ras_stack #(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         fire_i,
  input  logic         call_i,
  input  logic         ret_i,
  input  logic [W-1:0] push_data_i,
  output logic [W-1:0] top_o,
  output logic         empty_o,
  output logic         full_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic          wr_en;
  logic [PW-1:0] wr_idx;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign top_o   = mem_q[ptr_q];

  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = ptr_q;
    if (fire_i) begin
      // call+ret on an empty stack has no top to replace, so it pushes
      if (call_i && (!ret_i || empty_o)) begin
        wr_en  = 1'b1;
        wr_idx = ptr_q + PW'(1);
        ptr_d  = ptr_q + PW'(1);
        if (!full_o) cnt_d = cnt_q + CW'(1);
      end else if (call_i && ret_i) begin
        wr_en  = 1'b1;
      end else if (ret_i && !empty_o) begin
        ptr_d  = ptr_q - PW'(1);
        cnt_d  = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_idx] <= push_data_i;
  end

endmodule

// File: rtl/pc_gen_ras.sv
// Fetch next-PC generator with PC register; RAS present only when PC_GEN_RAS_EN is defined.
module pc_gen_ras
  import pc_gen_ras_pkg::*;
#(
  parameter int                  PC_WIDTH   = PC_WIDTH_DEF,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = PC_WIDTH'(RESET_PC_DEF),
  parameter int                  INST_BYTES = 4,
  parameter int                  RAS_DEPTH  = 8
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  pc_gen_ras_if.slave  bus
);
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] seq_pc, npc, ras_top;
  logic                ras_empty, ras_full, fire;
  npc_src_e            src;

  assign seq_pc = pc_q + PC_WIDTH'(INST_BYTES);
  assign fire   = !bus.stall_i && !bus.ex_redirect_i;

`ifdef PC_GEN_RAS_EN
  ras_stack #(.W(PC_WIDTH), .DEPTH(RAS_DEPTH)) u_ras (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .fire_i      (fire),
    .call_i      (bus.mini_op_call_i),
    .ret_i       (bus.mini_op_ret_i),
    .push_data_i (seq_pc),
    .top_o       (ras_top),
    .empty_o     (ras_empty),
    .full_o      (ras_full)
  );
`else
  // Permanently empty stack makes ret fall through to the lower priorities
  logic unused_ras;
  assign unused_ras = ^{bus.mini_op_call_i, fire};
  assign ras_top    = '0;
  assign ras_empty  = 1'b1;
  assign ras_full   = 1'b0;
`endif

  always_comb begin
    src = SRC_SEQ;
    if (bus.ex_redirect_i)                              src = SRC_REDIRECT;
    else if (bus.mini_op_ret_i && !ras_empty)           src = SRC_RAS;
    else if (bus.mini_op_branch_i && bus.F_train_predict_i) src = SRC_BRANCH;
    else if (bus.mini_op_jal_i)                         src = SRC_JAL;
    case (src)
      SRC_REDIRECT: npc = bus.ex_redirect_pc_i;
      SRC_RAS:      npc = ras_top;
      SRC_BRANCH:   npc = bus.mini_branch_jmp_i;
      SRC_JAL:      npc = bus.mini_jal_jmp_i;
      default:      npc = seq_pc;
    endcase
    pc_d = (bus.ex_redirect_i || !bus.stall_i) ? npc : pc_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) pc_q <= RESET_PC;
    else          pc_q <= pc_d;
  end

  assign bus.F_PC_o      = pc_q;
  assign bus.nPC_o       = npc;
  assign bus.ras_empty_o = ras_empty;
  assign bus.ras_full_o  = ras_full;

endmodule

// File: tb/tb_pc_gen_ras.sv
// Directed + random bench for pc_gen_ras against a queue-based reference model.
module tb_pc_gen_ras;
`ifdef PC_GEN_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif
  localparam int          DEPTH = 8;
  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pc_gen_ras_if #(.PC_WIDTH(32)) bus();

  pc_gen_ras #(.PC_WIDTH(32), .RESET_PC(RST_PC), .INST_BYTES(4), .RAS_DEPTH(DEPTH)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_npc();
    if (bus.ex_redirect_i)                                   return bus.ex_redirect_pc_i;
    if (RAS_EN && bus.mini_op_ret_i && m_ras.size() > 0)    return m_ras[m_ras.size()-1];
    if (bus.mini_op_branch_i && bus.F_train_predict_i)       return bus.mini_branch_jmp_i;
    if (bus.mini_op_jal_i)                                   return bus.mini_jal_jmp_i;
    return m_pc + 32'd4;
  endfunction

  function automatic logic m_empty();
    return !RAS_EN || m_ras.size() == 0;
  endfunction

  function automatic logic m_full();
    return RAS_EN && m_ras.size() == DEPTH;
  endfunction

  task automatic clr();
    bus.stall_i           = 1'b0;
    bus.ex_redirect_i     = 1'b0;
    bus.ex_redirect_pc_i  = '0;
    bus.mini_op_branch_i  = 1'b0;
    bus.F_train_predict_i = 1'b0;
    bus.mini_branch_jmp_i = '0;
    bus.mini_op_jal_i     = 1'b0;
    bus.mini_jal_jmp_i    = '0;
    bus.mini_op_call_i    = 1'b0;
    bus.mini_op_ret_i     = 1'b0;
  endtask

  // Called at negedge with inputs applied; checks comb outputs, clocks, checks state.
  task automatic cycle();
    logic [31:0] npc, old;
    npc = m_npc();
    #1;
    if (rst_n) begin
      chk("nPC", bus.nPC_o, npc);
      chk("empty_pre", {31'b0, bus.ras_empty_o}, {31'b0, m_empty()});
      chk("full_pre", {31'b0, bus.ras_full_o}, {31'b0, m_full()});
    end
    @(posedge clk);
    if (!rst_n) begin
      m_pc = RST_PC;
      m_ras.delete();
    end else begin
      old = m_pc;
      if (bus.ex_redirect_i || !bus.stall_i) m_pc = npc;
      if (RAS_EN && !bus.stall_i && !bus.ex_redirect_i) begin
        if (bus.mini_op_call_i && bus.mini_op_ret_i && m_ras.size() > 0)
          m_ras[m_ras.size()-1] = old + 32'd4;
        else if (bus.mini_op_call_i) begin
          m_ras.push_back(old + 32'd4);
          if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
        end else if (bus.mini_op_ret_i && m_ras.size() > 0)
          void'(m_ras.pop_back());
      end
    end
    #1;
    chk("F_PC", bus.F_PC_o, m_pc);
    chk("empty", {31'b0, bus.ras_empty_o}, {31'b0, m_empty()});
    chk("full", {31'b0, bus.ras_full_o}, {31'b0, m_full()});
    @(negedge clk);
  endtask

  task automatic redirect_to(input logic [31:0] a);
    clr();
    bus.ex_redirect_i    = 1'b1;
    bus.ex_redirect_pc_i = a;
    cycle();
    clr();
  endtask

  initial begin
    m_pc = 'x;
    clr();
    rst_n = 1'b0;
    bus.stall_i = 1'b1;
    @(negedge clk);
    cycle();
    chk("reset_pc", bus.F_PC_o, 32'h8000_0000);
    chk("reset_empty", {31'b0, bus.ras_empty_o}, 32'd1);
    rst_n = 1'b1;
    clr();
    cycle();
    cycle();
    chk("seq_pc", bus.F_PC_o, 32'h8000_0008);

    // branch beats jal, then jal wins when not predicted
    redirect_to(32'h8000_0010);
    bus.mini_op_branch_i = 1'b1; bus.F_train_predict_i = 1'b1;
    bus.mini_branch_jmp_i = 32'h8000_0100;
    bus.mini_op_jal_i = 1'b1; bus.mini_jal_jmp_i = 32'h8000_0200;
    cycle();
    chk("branch_wins", bus.F_PC_o, 32'h8000_0100);
    redirect_to(32'h8000_0010);
    bus.mini_op_branch_i = 1'b1; bus.F_train_predict_i = 1'b0;
    bus.mini_branch_jmp_i = 32'h8000_0100;
    bus.mini_op_jal_i = 1'b1; bus.mini_jal_jmp_i = 32'h8000_0200;
    cycle();
    chk("jal_wins", bus.F_PC_o, 32'h8000_0200);

    // call from 8000_0020, return from 8000_0408
    redirect_to(32'h8000_0020);
    bus.mini_op_call_i = 1'b1; bus.mini_op_jal_i = 1'b1; bus.mini_jal_jmp_i = 32'h8000_0400;
    cycle();
    clr();
    cycle();
    cycle();
    bus.mini_op_ret_i = 1'b1;
    cycle();
    chk("ret_target", bus.F_PC_o, RAS_EN ? 32'h8000_0024 : 32'h8000_040C);
    clr();

    // nine nested calls then nine returns
    redirect_to(32'h8000_1000);
    for (int i = 0; i < 9; i++) begin
      bus.mini_op_call_i = 1'b1; bus.mini_op_jal_i = 1'b1;
      bus.mini_jal_jmp_i = m_pc + 32'h100;
      cycle();
    end
    chk("full_after_9", {31'b0, bus.ras_full_o}, {31'b0, RAS_EN});
    clr();
    for (int i = 0; i < 9; i++) begin
      bus.mini_op_ret_i = 1'b1;
      cycle();
    end
    clr();

    // stalled call+ret holds everything; redirect overrides stall
    redirect_to(32'h8000_2000);
    bus.mini_op_call_i = 1'b1;
    cycle();
    bus.stall_i = 1'b1; bus.mini_op_call_i = 1'b1; bus.mini_op_ret_i = 1'b1;
    cycle();
    bus.ex_redirect_i = 1'b1; bus.ex_redirect_pc_i = 32'h8000_0800;
    cycle();
    chk("redirect_stall", bus.F_PC_o, 32'h8000_0800);
    clr();

    // sequential wrap
    redirect_to(32'hFFFF_FFFC);
    cycle();
    chk("wrap", bus.F_PC_o, 32'h0000_0000);

    for (int i = 0; i < 600; i++) begin
      rst_n                 = ($urandom_range(0, 99) >= 2);
      bus.stall_i           = ($urandom_range(0, 99) < 20);
      bus.ex_redirect_i     = ($urandom_range(0, 99) < 8);
      bus.ex_redirect_pc_i  = $urandom;
      bus.mini_op_branch_i  = ($urandom_range(0, 99) < 30);
      bus.F_train_predict_i = $urandom_range(0, 1);
      bus.mini_branch_jmp_i = $urandom;
      bus.mini_op_jal_i     = ($urandom_range(0, 99) < 20);
      bus.mini_jal_jmp_i    = $urandom;
      bus.mini_op_call_i    = ($urandom_range(0, 99) < 35);
      bus.mini_op_ret_i     = ($urandom_range(0, 99) < 25);
      cycle();
    end
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_gen_ras.md
Name: pc_gen_ras

Overview:
Fetch-stage next-PC generator with an owned PC register and a parametrised return address stack (RAS).
- Selects the next fetch PC from four sources: execute-stage redirect, RAS-predicted return target, predicted-taken branch target, jal target.
- Otherwise advances by INST_BYTES.
- Sits between the fetch mini-decoder and the instruction memory address port. Replaces the purely combinational next-PC mux.

Parameters:
PC_WIDTH, 32, width of all PC/target buses
RESET_PC, 32'h8000_0000, F_PC_o value after reset
INST_BYTES, 4, sequential increment
RAS_DEPTH, 8, RAS entries (power of two, >=2)

Ports:
clk_i  in  1  clock
rst_n_i  in  1  synchronous active-low reset
stall_i  in  1  hold PC and RAS this cycle
ex_redirect_i  in  1  execute-stage mispredict redirect
ex_redirect_pc_i  in  PC_WIDTH  correct PC on redirect
mini_op_branch_i  in  1  fetched inst is conditional branch
F_train_predict_i  in  1  branch predicted taken
mini_branch_jmp_i  in  PC_WIDTH  branch target
mini_op_jal_i  in  1  fetched inst is jal
mini_jal_jmp_i  in  PC_WIDTH  jal target
mini_op_call_i  in  1  call (jal/jalr with rd=x1/x5)
mini_op_ret_i  in  1  return (jalr rs1=x1/x5, rd=x0)
F_PC_o  out  PC_WIDTH  current fetch PC (registered)
nPC_o  out  PC_WIDTH  combinational next PC
ras_empty_o  out  1  RAS count == 0
ras_full_o  out  1  RAS count == RAS_DEPTH

Behaviour:
- Reset: synchronous, rst_n_i low at posedge, overrides everything including stall.
  - F_PC_o=RESET_PC.
  - RAS top pointer=0, count=0, ras_empty_o=1, ras_full_o=0. Entry contents are don't-care.
- nPC_o priority, highest first:
  1. ex_redirect_i -> ex_redirect_pc_i
  2. mini_op_ret_i & !ras_empty -> RAS top
  3. mini_op_branch_i & F_train_predict_i -> mini_branch_jmp_i
  4. mini_op_jal_i -> mini_jal_jmp_i
  5. otherwise F_PC_o+INST_BYTES
- Sequential add wraps modulo 2^PC_WIDTH. Targets are passed unmodified; no alignment masking.
- PC register:
  - At posedge, F_PC_o<=nPC_o if ex_redirect_i | !stall_i; else it holds.
  - Redirect overrides stall. Latency to fetch address is 1 cycle.
- RAS update occurs only when !stall_i & !ex_redirect_i ("fire"):
  - Push (call & !ret): write F_PC_o+INST_BYTES at ptr+1, ptr++, count=min(count+1,RAS_DEPTH).
    - When full, the circular pointer overwrites the oldest entry and count stays RAS_DEPTH.
  - Pop (ret & !call): ptr--, count-- when count>0.
    - Pop on empty: no state change, and nPC falls to the lower priorities.
  - Call & ret together: nPC_o=top (if non-empty), top entry replaced by F_PC_o+INST_BYTES, ptr and count unchanged.
    - If empty, this behaves as a push.
- Redirect does not repair or clear the RAS. Wrong-path pushes and pops persist.
- Pointer arithmetic is modulo RAS_DEPTH.

Optional Feature:
PC_GEN_RAS_EN
- Defined: RAS present as above.
- Undefined:
  - No RAS storage.
  - mini_op_call_i and mini_op_ret_i are ignored; ret follows the branch/jal/sequential priority.
  - ras_empty_o tied 1, ras_full_o tied 0.

Decomposition:
- Shared package/define file holds:
  - PC_WIDTH default and RESET_PC constant.
  - Next-PC source select encoding: SRC_REDIRECT, SRC_RAS, SRC_BRANCH, SRC_JAL, SRC_SEQ.
- One sub-module, ras_stack (storage, pointer, count, push/pop/replace, full/empty).
- Top contains the priority mux and PC register.

Test Plan:
- Reset with stall_i=1 -> F_PC_o=32'h8000_0000, ras_empty_o=1. Release with no ops -> F_PC_o steps 8000_0004, 8000_0008.
- At F_PC=8000_0010:
  - branch=1, predict=1, target 8000_0100, jal=1 -> F_PC_o=8000_0100 next cycle (branch beats jal).
  - predict=0 -> jal target wins.
- At F_PC=8000_0020: call, jal target 8000_0400 -> pushes 8000_0024. Later ret at 8000_0408 -> nPC_o=8000_0024, ras_empty_o=1 after pop.
- RAS_DEPTH=8: nine nested calls -> ras_full_o=1. Nine rets return the latest eight addresses in LIFO order. The ninth ret has empty RAS and follows PC+4.
- stall_i=1 with call and ret asserted -> PC and RAS unchanged. Same cycle with ex_redirect_i=1, pc 8000_0800 -> F_PC_o=8000_0800, RAS unchanged.
- PC_WIDTH=32, F_PC=FFFF_FFFC, no ops -> F_PC_o=0000_0000. Build without PC_GEN_RAS_EN, ret asserted -> follows PC+4.
